// File: rtl/smc_pkg.sv
// Shared constants and types for the weighted-sum chooser front end.
// Holds the frame geometry, loader state encoding and mode encodings.
package smc_pkg;

    localparam int SMC_W = 10;
    localparam int SMC_N = 6;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } smc_ld_state_t;

    localparam logic [1:0] MODE_HI_SUM  = 2'b00;
    localparam logic [1:0] MODE_HI_WSUM = 2'b01;
    localparam logic [1:0] MODE_LO_SUM  = 2'b10;
    localparam logic [1:0] MODE_LO_WSUM = 2'b11;

endpackage

// File: rtl/smc_sort_loader_if.sv
// Serial value stream in, sorted parallel frame out.
// master = the loader itself, slave = the producer/consumer environment.
interface smc_sort_loader_if #(
    parameter int W = 10
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   mode;
    logic [W-1:0] n0, n1, n2, n3, n4, n5;

    modport master (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, mode, n0, n1, n2, n3, n4, n5
    );

    modport slave (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, mode, n0, n1, n2, n3, n4, n5
    );

endinterface

// File: rtl/smc_sort_cell.sv
// One slot of the insertion sorter: decides whether this slot keeps its
// value, takes its left neighbour's value, or takes the arriving value.
module smc_sort_cell #(
    parameter int W = 10
) (
    input  logic [W-1:0] slot,
    input  logic [W-1:0] left,
    input  logic [W-1:0] new_value,
    input  logic         filled,
    input  logic         left_filled,
    output logic [W-1:0] next_value,
    output logic         goes_right
);

    logic left_goes_right;

    // "<=" keeps ties stable: an equal newcomer lands after existing equals.
    assign goes_right      = filled && (slot <= new_value);
    assign left_goes_right = left_filled && (left <= new_value);

    assign next_value = goes_right                         ? slot :
                        (left_filled && !left_goes_right)  ? left :
                                                             new_value;

endmodule

// File: rtl/smc_sort_loader.sv
// Collects N serial values, insertion-sorts them on arrival and presents
// the sorted frame plus the mode captured with the first value.
module smc_sort_loader
    import smc_pkg::*;
#(
    parameter int W = SMC_W,
    parameter int N = SMC_N
) (
    input  logic             clk,
    input  logic             rst_n,
    smc_sort_loader_if.master bus
);

    localparam logic [2:0] LAST = 3'(N - 1);

    smc_ld_state_t state;
    logic [2:0]    count;
    logic [1:0]    mode_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  slot      [N];
    logic [W-1:0]  next_slot [N];
    logic [N-1:0]  filled;
    logic [N-1:0]  goes_right;

    for (genvar i = 0; i < N; i++) begin : g_cell
        logic [W-1:0] left_value;
        logic         left_filled;

        if (i == 0) begin : g_first
            assign left_value  = '0;
            assign left_filled = 1'b0;
        end else begin : g_rest
            assign left_value  = slot[i-1];
            assign left_filled = filled[i-1];
        end

        assign filled[i] = (3'(i) < count);

        smc_sort_cell #(.W(W)) u_cell (
            .slot        (slot[i]),
            .left        (left_value),
            .new_value   (bus.in_data),
            .filled      (filled[i]),
            .left_filled (left_filled),
            .next_value  (next_slot[i]),
            .goes_right  (goes_right[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD;
            count       <= '0;
            mode_r      <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            // NOTE: the slot array is small and its reset value is observable
            // on n0..n5, so it is reset explicitly rather than left undefined.
            for (int i = 0; i < N; i++) slot[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        // Slots left of the insertion point keep their value.
                        for (int i = 0; i < N; i++) begin
                            if (!goes_right[i]) slot[i] <= next_slot[i];
                        end
                        if (count == '0) mode_r <= bus.in_mode;
                        if (count == LAST) begin
                            count       <= '0;
                            state       <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            count <= count + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= LOAD;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.mode      = mode_r;
    assign bus.n0        = slot[0];
    assign bus.n1        = slot[1];
    assign bus.n2        = slot[2];
    assign bus.n3        = slot[3];
    assign bus.n4        = slot[4];
    assign bus.n5        = slot[5];

endmodule

// File: doc/smc_sort_loader.md
SMC_SORT_LOADER -- requirements
Module: smc_sort_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- W, 10, data width.
- N, 6, values per frame.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, 1, in_data/in_mode present.
- in_ready, out, 1, block accepts a value this cycle.
- in_data, in, W, one unsigned value.
- in_mode, in, 2, frame mode; sampled with the first value of a frame only.
- out_valid, out, 1, sorted frame presented.
- out_ready, in, 1, consumer takes the frame.
- mode, out, 2, captured frame mode.
- n0..n5, out, W each, sorted frame, ascending (n0 smallest, n5 largest).

Function
REQ-004 The block SHALL be a frame producer for the weighted-sum chooser: it collects N serial values, sorts them, and presents them in parallel with the mode.
REQ-005 A value SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1.
REQ-006 States SHALL be:
- LOAD: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-007 State transitions SHALL be:
- LOAD to HOLD on the acceptance that brings the count to N.
- HOLD to LOAD on a cycle with out_valid=1 and out_ready=1.
REQ-008 A 3-bit count SHALL track accepted values. It increments on each acceptance and clears to 0 on entering HOLD.
REQ-009 in_mode SHALL be captured into mode on acceptance when count=0. in_mode SHALL be ignored on all other acceptances.
REQ-010 Sorting SHALL be by insertion on arrival. The new value goes at index p, where p is the number of filled slots whose value is <= in_data. Filled slots at p and above shift up one index in the same cycle.
REQ-011 Ties SHALL be stable: an equal value lands after every existing equal value.
REQ-012 Comparisons SHALL be unsigned, full W bits. No arithmetic beyond compare/shift is permitted.
REQ-013 out_valid SHALL rise on the cycle after the Nth acceptance. Latency from the Nth accept edge to out_valid=1 is one clock.
REQ-014 In HOLD, n0..n5 and mode SHALL stay stable until the handshake completes, regardless of in_valid.
REQ-015 in_valid during HOLD SHALL be ignored: no acceptance and no state change.
REQ-016 On the HOLD-to-LOAD handshake edge, slot registers SHALL be retained; count=0 marks them empty. The first value of the next frame is accepted no earlier than the following cycle.
REQ-017 Back-to-back frames SHALL be sustainable at N+1 cycles per frame.
REQ-018 n0..n5 during LOAD SHALL be don't-care for consumers; only out_valid qualifies them.
REQ-019 in_ready SHALL be a registered-state decode with no combinational path from out_ready or in_valid.

Reset
REQ-020 When rst_n=0 at a clk edge, the block SHALL enter LOAD with count=0, mode=2'b00, n0..n5=0, out_valid=0, and in_ready=1 from the next cycle.
REQ-021 Reset SHALL dominate any simultaneous acceptance or handshake. A partial frame in progress is discarded.

Structure
REQ-022 A shared package smc_pkg SHALL hold:
- constants SMC_W=10 and SMC_N=6;
- the state typedef smc_ld_state_t {LOAD, HOLD};
- the 2-bit mode encodings MODE_HI_SUM=00, MODE_HI_WSUM=01, MODE_LO_SUM=10, MODE_LO_WSUM=11.
REQ-023 One sub-module, smc_sort_cell, SHALL implement a single slot, instantiated N times. Its inputs are the slot value, the left-neighbour value, the new value, the filled flag and the left-filled flag. It outputs next value and a "goes_right" flag.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- V1: in_mode=01, data 7,3,9,1,5,2 back-to-back -> out_valid 1 cycle after 6th accept; n0..n5=1,2,3,5,7,9; mode=01.
- V2: data 4,4,0,1023,4,0 -> n0..n5=0,0,4,4,4,1023; boundary 1023 is not treated as signed.
- V3: frame accepted, out_ready=0 for 5 cycles while in_valid=1 with data 8 -> outputs stable, in_ready=0, no count change. Then out_ready=1 -> out_valid=0 next cycle; the next frame 6,5,4,3,2,1 with mode 10 yields 1..6, mode=10.
- V4: three accepted values 9,8,7, then rst_n=0 for one cycle -> all outputs zero. The new frame 1,1,1,1,1,2 yields 1,1,1,1,1,2 with no residue of 7/8/9.
- V5: in_valid gapped (values on alternate cycles) with mode 11 on first and 00 on later beats -> mode=11 and sorted result correct.
- V6: continuous in_valid=1 and out_ready=1 for 3 frames -> one frame every 7 cycles; each result correct.
